cnn_bist_loader: RTL and testbench

//  Synthesizable built-in self-test driver for the CNN inference core. Fills the image BRAM

---
 rtl/cnn_bist_loader_pkg.sv | 27 ++
 rtl/cnn_bist_loader_if.sv | 27 ++
 rtl/cnn_bist_loader_pattern_gen.sv | 37 +++
 rtl/cnn_bist_loader.sv | 189 ++++++++++++++++++
 tb/tb_cnn_bist_loader.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_bist_loader_pkg.sv
// Shared types for the CNN BIST loader: FSM states, pattern modes, checksum width
// and a width helper that never returns zero.
package cnn_bist_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        KICK = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } bist_state_t;

    typedef enum logic [1:0] {
        MODE_GRADIENT = 2'd0,
        MODE_CONST    = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_EXT      = 2'd3
    } bist_mode_t;

    localparam int unsigned CSUM_W = 16;

    // Counter width for a range of n values; a one-value range still needs one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnn_bist_loader_if.sv
// Core-side bus of the BIST loader: image BRAM write port, start/done handshake
// and the external pixel stream used in mode 3.
interface cnn_bist_loader_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned RES_W  = 8
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              dut_start;
    logic              dut_done;
    logic [RES_W-1:0]  dut_result;
    logic              ext_valid;
    logic [PIX_W-1:0]  ext_data;
    logic              ext_ready;

    modport master (
        output wr_en, wr_addr, wr_data, dut_start, ext_ready,
        input  dut_done, dut_result, ext_valid, ext_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, dut_start, ext_ready,
        output dut_done, dut_result, ext_valid, ext_data
    );
endinterface

// File: rtl/cnn_bist_loader_pattern_gen.sv
// Combinational test-pattern generator: maps pixel coordinates and mode to a pixel value,
// saturating the gradient at the pixel full-scale value.
module cnn_bist_loader_pattern_gen
    import cnn_bist_loader_pkg::*;
#(
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned X_STEP    = 8,
    parameter int unsigned Y_STEP    = 4,
    parameter int unsigned C_STEP    = 16,
    parameter int unsigned CONST_VAL = 128,
    parameter int unsigned XW        = 5,
    parameter int unsigned YW        = 5,
    parameter int unsigned CW        = 1
) (
    input  logic [XW-1:0]    i_x,
    input  logic [YW-1:0]    i_y,
    input  logic [CW-1:0]    i_c,
    input  bist_mode_t       i_mode,
    output logic [PIX_W-1:0] o_pixel
);

    localparam logic [31:0] PIX_MAX = 32'((64'd1 << PIX_W) - 64'd1);

    logic [31:0] w_grad;

    always_comb begin
        w_grad  = 32'(i_x) * X_STEP + 32'(i_y) * Y_STEP + 32'(i_c) * C_STEP;
        o_pixel = '0;
        unique case (i_mode)
            MODE_GRADIENT: o_pixel = (w_grad > PIX_MAX) ? '1 : w_grad[PIX_W-1:0];
            MODE_CONST:    o_pixel = PIX_W'(CONST_VAL);
            MODE_CHECKER:  o_pixel = (i_x[0] ^ i_y[0] ^ i_c[0]) ? '1 : '0;
            default:       o_pixel = '0;
        endcase
    end

endmodule

// File: rtl/cnn_bist_loader.sv
// BIST driver for the CNN core: fills the image BRAM, kicks the core, waits for done
// and checks the result. Optional pixel checksum enabled by CNN_BIST_CHECKSUM_EN.
module cnn_bist_loader
    import cnn_bist_loader_pkg::*;
#(
    parameter int unsigned IMG_W     = 28,
    parameter int unsigned IMG_H     = 28,
    parameter int unsigned CHANNELS  = 1,
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned RES_W     = 8,
    parameter int unsigned X_STEP    = 8,
    parameter int unsigned Y_STEP    = 4,
    parameter int unsigned C_STEP    = 16,
    parameter int unsigned CONST_VAL = 128,
    parameter int unsigned TIMEOUT   = 2**20,
    parameter int unsigned ADDR_W    = $clog2(IMG_W*IMG_H*CHANNELS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic [1:0]         mode,
    input  logic [RES_W-1:0]   expected,
    cnn_bist_loader_if.master  bus,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [RES_W-1:0]   result,
    output logic [CSUM_W-1:0]  checksum
);

    localparam int unsigned XW = width_of(IMG_W);
    localparam int unsigned YW = width_of(IMG_H);
    localparam int unsigned CW = width_of(CHANNELS);
    localparam int unsigned TW = width_of(TIMEOUT);

    bist_state_t       r_state;
    bist_state_t       w_next;
    bist_mode_t        r_mode;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [CW-1:0]     r_c;
    logic [ADDR_W-1:0] r_addr;
    logic [TW-1:0]     r_tcnt;
    logic              r_pass;
    logic              r_tmo;
    logic [RES_W-1:0]  r_result;

    logic              w_ext;
    logic              w_wr;
    logic              w_x_end;
    logic              w_y_end;
    logic              w_c_end;
    logic              w_last;
    logic              w_go_acc;
    logic              w_tmo_hit;
    logic [PIX_W-1:0]  w_pix;

    assign w_ext     = (r_mode == MODE_EXT);
    assign w_wr      = (r_state == LOAD) && (!w_ext || bus.ext_valid);
    assign w_x_end   = (r_x == XW'(IMG_W - 1));
    assign w_y_end   = (r_y == YW'(IMG_H - 1));
    assign w_c_end   = (r_c == CW'(CHANNELS - 1));
    assign w_last    = w_x_end && w_y_end && w_c_end;
    assign w_go_acc  = go && ((r_state == IDLE) || (r_state == DONE));
    assign w_tmo_hit = (r_tcnt == TW'(TIMEOUT - 1));

    cnn_bist_loader_pattern_gen #(
        .PIX_W     (PIX_W),
        .X_STEP    (X_STEP),
        .Y_STEP    (Y_STEP),
        .C_STEP    (C_STEP),
        .CONST_VAL (CONST_VAL),
        .XW        (XW),
        .YW        (YW),
        .CW        (CW)
    ) u_pattern (
        .i_x     (r_x),
        .i_y     (r_y),
        .i_c     (r_c),
        .i_mode  (r_mode),
        .o_pixel (w_pix)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (go) w_next = LOAD;
            LOAD:    if (w_wr && w_last) w_next = KICK;
            KICK:    w_next = WAIT;
            WAIT:    if (bus.dut_done || w_tmo_hit) w_next = DONE;
            DONE:    if (go) w_next = LOAD;
            default: w_next = IDLE;
        endcase
    end

    // Pixel coordinates and address advance together; all wrap to 0 on the last pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode   <= MODE_GRADIENT;
            r_x      <= '0;
            r_y      <= '0;
            r_c      <= '0;
            r_addr   <= '0;
            r_tcnt   <= '0;
            r_pass   <= 1'b0;
            r_tmo    <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_go_acc) begin
                r_mode   <= bist_mode_t'(mode);
                r_x      <= '0;
                r_y      <= '0;
                r_c      <= '0;
                r_addr   <= '0;
                r_pass   <= 1'b0;
                r_tmo    <= 1'b0;
                r_result <= '0;
            end
            if (w_wr) begin
                r_addr <= w_last ? '0 : r_addr + ADDR_W'(1);
                if (!w_x_end) begin
                    r_x <= r_x + XW'(1);
                end else begin
                    r_x <= '0;
                    if (!w_y_end) begin
                        r_y <= r_y + YW'(1);
                    end else begin
                        r_y <= '0;
                        r_c <= w_c_end ? '0 : r_c + CW'(1);
                    end
                end
            end
            // Count is 1 in the first WAIT cycle, so the abort lands TIMEOUT cycles after dut_start.
            if (r_state == KICK) begin
                r_tcnt <= TW'(1);
            end else if (r_state == WAIT) begin
                r_tcnt <= r_tcnt + TW'(1);
            end
            if (r_state == WAIT) begin
                if (bus.dut_done) begin
                    r_result <= bus.dut_result;
                    r_pass   <= (bus.dut_result == expected);
                end else if (w_tmo_hit) begin
                    r_tmo <= 1'b1;
                end
            end
        end
    end

    assign bus.wr_en     = w_wr;
    assign bus.wr_addr   = r_addr;
    assign bus.wr_data   = w_wr ? (w_ext ? bus.ext_data : w_pix) : '0;
    assign bus.dut_start = (r_state == KICK);
    assign bus.ext_ready = (r_state == LOAD) && w_ext;

    assign busy    = (r_state == LOAD) || (r_state == KICK) || (r_state == WAIT);
    assign done    = (r_state == DONE);
    assign pass    = r_pass;
    assign timeout = r_tmo;
    assign result  = r_result;

`ifdef CNN_BIST_CHECKSUM_EN
    logic [CSUM_W-1:0] r_csum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_csum <= '0;
        end else if (w_go_acc) begin
            r_csum <= '0;
        end else if (w_wr) begin
            r_csum <= r_csum + CSUM_W'(bus.wr_data);
        end
    end

    assign checksum = r_csum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_cnn_bist_loader.sv
// Directed bench for cnn_bist_loader: 28x28x1 gradient/timeout/reset runs, a 4x4x2
// external-stream run and 4x4x1 constant/checkerboard runs with checksum.
module tb_cnn_bist_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

`ifdef CNN_BIST_CHECKSUM_EN
    localparam logic [15:0] EXP_CSUM_CONST   = 16'd2048;
    localparam logic [15:0] EXP_CSUM_CHECKER = 16'd2040;
`else
    localparam logic [15:0] EXP_CSUM_CONST   = 16'd0;
    localparam logic [15:0] EXP_CSUM_CHECKER = 16'd0;
`endif

    // Instance A: 28x28x1, TIMEOUT 64
    logic        a_rst, a_go, a_busy, a_done, a_pass, a_tmo;
    logic [1:0]  a_mode;
    logic [7:0]  a_exp, a_res;
    logic [15:0] a_csum;
    cnn_bist_loader_if #(.ADDR_W(10), .PIX_W(8), .RES_W(8)) a_bus ();
    cnn_bist_loader #(
        .IMG_W(28), .IMG_H(28), .CHANNELS(1), .PIX_W(8), .RES_W(8), .TIMEOUT(64), .ADDR_W(10)
    ) dut_a (
        .clk(clk), .reset(a_rst), .go(a_go), .mode(a_mode), .expected(a_exp), .bus(a_bus),
        .busy(a_busy), .done(a_done), .pass(a_pass), .timeout(a_tmo), .result(a_res), .checksum(a_csum)
    );

    // Instance B: 4x4x2 external stream
    logic        b_rst, b_go, b_busy, b_done, b_pass, b_tmo;
    logic [1:0]  b_mode;
    logic [7:0]  b_exp, b_res;
    logic [15:0] b_csum;
    cnn_bist_loader_if #(.ADDR_W(5), .PIX_W(8), .RES_W(8)) b_bus ();
    cnn_bist_loader #(
        .IMG_W(4), .IMG_H(4), .CHANNELS(2), .PIX_W(8), .RES_W(8), .TIMEOUT(64), .ADDR_W(5)
    ) dut_b (
        .clk(clk), .reset(b_rst), .go(b_go), .mode(b_mode), .expected(b_exp), .bus(b_bus),
        .busy(b_busy), .done(b_done), .pass(b_pass), .timeout(b_tmo), .result(b_res), .checksum(b_csum)
    );

    // Instance C: 4x4x1 constant / checkerboard, core done held high
    logic        c_rst, c_go, c_busy, c_done, c_pass, c_tmo;
    logic [1:0]  c_mode;
    logic [7:0]  c_exp, c_res;
    logic [15:0] c_csum;
    cnn_bist_loader_if #(.ADDR_W(4), .PIX_W(8), .RES_W(8)) c_bus ();
    cnn_bist_loader #(
        .IMG_W(4), .IMG_H(4), .CHANNELS(1), .PIX_W(8), .RES_W(8), .TIMEOUT(64), .ADDR_W(4)
    ) dut_c (
        .clk(clk), .reset(c_rst), .go(c_go), .mode(c_mode), .expected(c_exp), .bus(c_bus),
        .busy(c_busy), .done(c_done), .pass(c_pass), .timeout(c_tmo), .result(c_res), .checksum(c_csum)
    );

    // Stimulus only: watches A's LOAD phase until dut_start, gathering what was written.
    task automatic a_watch_load(output int nwr, output int addr_err, output int gaps,
                                output logic [7:0] d29, output logic [7:0] d40,
                                output logic [7:0] d783, output bit started);
        nwr = 0; addr_err = 0; gaps = 0; started = 1'b0;
        d29 = '0; d40 = '0; d783 = '0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (a_bus.dut_start === 1'b1) begin
                started = 1'b1;
                break;
            end
            if (a_bus.wr_en === 1'b1) begin
                if (a_bus.wr_addr !== 10'(nwr)) addr_err++;
                if (nwr == 29)  d29  = a_bus.wr_data;
                if (nwr == 40)  d40  = a_bus.wr_data;
                if (nwr == 783) d783 = a_bus.wr_data;
                nwr++;
            end else begin
                gaps++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic a_pulse_go();
        a_go = 1'b1;
        @(posedge clk); #1;
        a_go = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({a_busy, a_done, a_pass, a_tmo} !== 4'b0000) begin
            bad++; $display("FAIL reset_status: got %b want 0000", {a_busy, a_done, a_pass, a_tmo});
        end
        total++;
        if (a_res !== 8'd0 || a_csum !== 16'd0) begin
            bad++; $display("FAIL reset_result: got res=%0d csum=%0d want 0/0", a_res, a_csum);
        end
        total++;
        if ({a_bus.wr_en, a_bus.dut_start, a_bus.ext_ready} !== 3'b000 || a_bus.wr_addr !== 10'd0
            || a_bus.wr_data !== 8'd0) begin
            bad++; $display("FAIL reset_bus: got en/start/ready=%b addr=%0d data=%0d want 000/0/0",
                            {a_bus.wr_en, a_bus.dut_start, a_bus.ext_ready}, a_bus.wr_addr, a_bus.wr_data);
        end
    endtask

    task automatic test_gradient_pass();
        int nwr, aerr, gaps;
        logic [7:0] d29, d40, d783;
        bit st;
        a_mode = 2'd0; a_exp = 8'd7;
        a_pulse_go();
        a_watch_load(nwr, aerr, gaps, d29, d40, d783, st);
        total++;
        if (!st || nwr != 784 || gaps != 0) begin
            bad++; $display("FAIL grad_count: got start=%0d writes=%0d gaps=%0d want 1/784/0", st, nwr, gaps);
        end
        total++;
        if (aerr != 0) begin bad++; $display("FAIL grad_addr: got %0d bad addresses want 0", aerr); end
        total++;
        if (d29 !== 8'd12) begin bad++; $display("FAIL grad_a29: got %0d want 12", d29); end
        total++;
        if (d40 !== 8'd100) begin bad++; $display("FAIL grad_a40: got %0d want 100", d40); end
        total++;
        if (d783 !== 8'd255) begin bad++; $display("FAIL grad_a783: got %0d want 255", d783); end
        @(posedge clk); #1;
        total++;
        if (a_bus.dut_start !== 1'b0 || a_busy !== 1'b1 || a_bus.wr_en !== 1'b0) begin
            bad++; $display("FAIL start_width: got start=%b busy=%b wr_en=%b want 0/1/0",
                            a_bus.dut_start, a_busy, a_bus.wr_en);
        end
        repeat (9) begin @(posedge clk); #1; end
        total++;
        if (a_done !== 1'b0) begin bad++; $display("FAIL wait_done: got %b want 0", a_done); end
        a_bus.dut_result = 8'd7; a_bus.dut_done = 1'b1;
        @(posedge clk); #1;
        a_bus.dut_done = 1'b0;
        total++;
        if ({a_done, a_pass, a_tmo, a_busy} !== 4'b1100 || a_res !== 8'd7) begin
            bad++; $display("FAIL pass_run: got done/pass/tmo/busy=%b res=%0d want 1100/7",
                            {a_done, a_pass, a_tmo, a_busy}, a_res);
        end
    endtask

    task automatic test_gradient_fail();
        int nwr, aerr, gaps;
        logic [7:0] d29, d40, d783;
        bit st;
        a_pulse_go();
        total++;
        if ({a_done, a_pass, a_busy} !== 3'b001 || a_res !== 8'd0) begin
            bad++; $display("FAIL rerun_clear: got done/pass/busy=%b res=%0d want 001/0",
                            {a_done, a_pass, a_busy}, a_res);
        end
        a_watch_load(nwr, aerr, gaps, d29, d40, d783, st);
        total++;
        if (!st || nwr != 784 || aerr != 0 || d40 !== 8'd100 || d783 !== 8'd255) begin
            bad++; $display("FAIL rerun_load: got start=%0d writes=%0d aerr=%0d d40=%0d d783=%0d want 1/784/0/100/255",
                            st, nwr, aerr, d40, d783);
        end
        repeat (10) begin @(posedge clk); #1; end
        a_bus.dut_result = 8'd3; a_bus.dut_done = 1'b1;
        @(posedge clk); #1;
        a_bus.dut_done = 1'b0;
        total++;
        if ({a_done, a_pass, a_tmo} !== 3'b100 || a_res !== 8'd3) begin
            bad++; $display("FAIL fail_run: got done/pass/tmo=%b res=%0d want 100/3", {a_done, a_pass, a_tmo}, a_res);
        end
    endtask

    task automatic test_timeout();
        int nwr, aerr, gaps, lat;
        logic [7:0] d29, d40, d783;
        bit st;
        a_pulse_go();
        a_watch_load(nwr, aerr, gaps, d29, d40, d783, st);
        lat = -1;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); #1;
            if (a_done === 1'b1) begin lat = i; break; end
        end
        total++;
        if (!st || lat != 64) begin
            bad++; $display("FAIL tmo_latency: got start=%0d latency=%0d want 1/64", st, lat);
        end
        total++;
        if ({a_done, a_tmo, a_pass} !== 3'b110 || a_res !== 8'd0) begin
            bad++; $display("FAIL tmo_flags: got done/tmo/pass=%b res=%0d want 110/0", {a_done, a_tmo, a_pass}, a_res);
        end
    endtask

    task automatic test_reset_mid_load();
        bit hit;
        a_mode = 2'd0;
        a_pulse_go();
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (a_bus.wr_en === 1'b1 && a_bus.wr_addr === 10'd100) begin hit = 1'b1; break; end
            @(posedge clk); #1;
        end
        total++;
        if (!hit) begin bad++; $display("FAIL midload_reach: got no write to addr 100 want one"); end
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        total++;
        if ({a_bus.wr_en, a_busy, a_done} !== 3'b000) begin
            bad++; $display("FAIL midload_abort: got wr_en/busy/done=%b want 000", {a_bus.wr_en, a_busy, a_done});
        end
        a_pulse_go();
        total++;
        if (a_bus.wr_en !== 1'b1 || a_bus.wr_addr !== 10'd0 || a_bus.wr_data !== 8'd0) begin
            bad++; $display("FAIL restart_first: got en=%b addr=%0d data=%0d want 1/0/0",
                            a_bus.wr_en, a_bus.wr_addr, a_bus.wr_data);
        end
        @(posedge clk); #1;
        total++;
        if (a_bus.wr_addr !== 10'd1 || a_bus.wr_data !== 8'd8) begin
            bad++; $display("FAIL restart_second: got addr=%0d data=%0d want 1/8", a_bus.wr_addr, a_bus.wr_data);
        end
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
    endtask

    task automatic test_ext_stream();
        int nwr, aerr, derr, spur, rerr, start_cyc;
        bit phase;
        total++;
        if (b_bus.ext_ready !== 1'b0) begin bad++; $display("FAIL ext_idle_ready: got %b want 0", b_bus.ext_ready); end
        b_mode = 2'd3; b_exp = 8'h5A;
        b_go = 1'b1;
        @(posedge clk); #1;
        b_go = 1'b0;
        b_mode = 2'd0;
        nwr = 0; aerr = 0; derr = 0; spur = 0; rerr = 0; start_cyc = -1; phase = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            b_bus.ext_valid = phase;
            b_bus.ext_data  = 8'(nwr * 7 + 3);
            b_go = (cyc == 5);
            #1;
            if (b_bus.dut_start === 1'b1) begin start_cyc = cyc; break; end
            if (b_bus.ext_ready !== 1'b1) rerr++;
            if (phase) begin
                if (b_bus.wr_en !== 1'b1) begin
                    spur++;
                end else begin
                    if (b_bus.wr_addr !== 5'(nwr)) aerr++;
                    if (b_bus.wr_data !== 8'(nwr * 7 + 3)) derr++;
                    nwr++;
                end
            end else if (b_bus.wr_en !== 1'b0) begin
                spur++;
            end
            phase = !phase;
            @(posedge clk); #1;
        end
        b_go = 1'b0;
        b_bus.ext_valid = 1'b0;
        total++;
        if (nwr != 32 || start_cyc != 63) begin
            bad++; $display("FAIL ext_count: got writes=%0d start_cycle=%0d want 32/63", nwr, start_cyc);
        end
        total++;
        if (aerr != 0 || derr != 0) begin
            bad++; $display("FAIL ext_order: got addr_err=%0d data_err=%0d want 0/0", aerr, derr);
        end
        total++;
        if (spur != 0 || rerr != 0) begin
            bad++; $display("FAIL ext_handshake: got wr_en_err=%0d ready_err=%0d want 0/0", spur, rerr);
        end
        @(posedge clk); #1;
        b_bus.dut_result = 8'h5A; b_bus.dut_done = 1'b1;
        @(posedge clk); #1;
        b_bus.dut_done = 1'b0;
        total++;
        if ({b_done, b_pass, b_tmo} !== 3'b110 || b_res !== 8'h5A) begin
            bad++; $display("FAIL ext_result: got done/pass/tmo=%b res=%0h want 110/5a", {b_done, b_pass, b_tmo}, b_res);
        end
    endtask

    task automatic test_constant_checksum();
        int nwr, derr, start_cyc;
        c_mode = 2'd1;
        c_go = 1'b1;
        @(posedge clk); #1;
        c_go = 1'b0;
        nwr = 0; derr = 0; start_cyc = -1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (c_bus.dut_start === 1'b1) begin start_cyc = cyc; break; end
            if (c_bus.wr_en === 1'b1) begin
                if (c_bus.wr_data !== 8'd128) derr++;
                nwr++;
            end
            @(posedge clk); #1;
        end
        total++;
        if (nwr != 16 || derr != 0 || start_cyc != 16) begin
            bad++; $display("FAIL const_load: got writes=%0d data_err=%0d start=%0d want 16/0/16", nwr, derr, start_cyc);
        end
        total++;
        if (c_csum !== EXP_CSUM_CONST) begin
            bad++; $display("FAIL const_checksum: got %0d want %0d", c_csum, EXP_CSUM_CONST);
        end
        repeat (2) begin @(posedge clk); #1; end
        total++;
        if ({c_done, c_pass} !== 2'b11 || c_csum !== EXP_CSUM_CONST) begin
            bad++; $display("FAIL const_done: got done/pass=%b csum=%0d want 11/%0d", {c_done, c_pass}, c_csum, EXP_CSUM_CONST);
        end
    endtask

    task automatic test_checkerboard();
        logic [7:0] d [16];
        int nwr;
        for (int i = 0; i < 16; i++) d[i] = 8'hxx;
        c_mode = 2'd2;
        c_go = 1'b1;
        @(posedge clk); #1;
        c_go = 1'b0;
        nwr = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (c_bus.dut_start === 1'b1) break;
            if (c_bus.wr_en === 1'b1 && nwr < 16) begin
                d[c_bus.wr_addr] = c_bus.wr_data;
                nwr++;
            end
            @(posedge clk); #1;
        end
        total++;
        if (d[0] !== 8'd0 || d[1] !== 8'd255 || d[3] !== 8'd255) begin
            bad++; $display("FAIL checker_row0: got %0d %0d %0d want 0 255 255", d[0], d[1], d[3]);
        end
        total++;
        if (d[4] !== 8'd255 || d[5] !== 8'd0 || d[15] !== 8'd0) begin
            bad++; $display("FAIL checker_rows: got %0d %0d %0d want 255 0 0", d[4], d[5], d[15]);
        end
        total++;
        if (nwr != 16 || c_csum !== EXP_CSUM_CHECKER) begin
            bad++; $display("FAIL checker_checksum: got writes=%0d csum=%0d want 16/%0d", nwr, c_csum, EXP_CSUM_CHECKER);
        end
    endtask

    initial begin
        a_rst = 1'b1; a_go = 1'b0; a_mode = 2'd0; a_exp = 8'd0;
        b_rst = 1'b1; b_go = 1'b0; b_mode = 2'd0; b_exp = 8'd0;
        c_rst = 1'b1; c_go = 1'b0; c_mode = 2'd0; c_exp = 8'h11;
        a_bus.dut_done = 1'b0; a_bus.dut_result = 8'd0; a_bus.ext_valid = 1'b0; a_bus.ext_data = 8'd0;
        b_bus.dut_done = 1'b0; b_bus.dut_result = 8'd0; b_bus.ext_valid = 1'b0; b_bus.ext_data = 8'd0;
        c_bus.dut_done = 1'b1; c_bus.dut_result = 8'h11; c_bus.ext_valid = 1'b0; c_bus.ext_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

        test_reset();
        test_gradient_pass();
        test_gradient_fail();
        test_timeout();
        test_reset_mid_load();
        test_ext_stream();
        test_constant_checksum();
        test_checkerboard();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
